// File: rtl/fwft_thresh_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fwft_thresh_fifo
//  Brief    : First-word-fallthrough FIFO with registered head output,
//             programmable nearly-full/empty thresholds and sticky error flags.
//  Revision : 1.0  - initial release
// ============================================================================
module fwft_thresh_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3,
  parameter int NEARLY_FULL    = 2**MAX_DEPTH_BITS - 1,
  parameter int NEARLY_EMPTY   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          din,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic                      err_clr,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      nearly_full,
  output logic                      empty,
  output logic                      nearly_empty,
  output logic [MAX_DEPTH_BITS:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int MAX_DEPTH = 2**MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] c_full_cnt  = (MAX_DEPTH_BITS+1)'(MAX_DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] c_nf_thresh = (MAX_DEPTH_BITS+1)'(NEARLY_FULL);
  localparam logic [MAX_DEPTH_BITS:0] c_ne_thresh = (MAX_DEPTH_BITS+1)'(NEARLY_EMPTY);
  localparam logic [MAX_DEPTH_BITS:0] c_one       = (MAX_DEPTH_BITS+1)'(1);
  localparam logic [MAX_DEPTH_BITS-1:0] c_ptr_one = MAX_DEPTH_BITS'(1);

  logic [WIDTH-1:0]          r_mem [MAX_DEPTH];
  logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
  logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
  logic [MAX_DEPTH_BITS:0]   r_count;
  logic [WIDTH-1:0]          r_dout;
  logic                      r_overflow;
  logic                      r_underflow;

  logic                      w_full;
  logic                      w_empty;
  logic                      w_wr_acc;
  logic                      w_rd_acc;
  logic [MAX_DEPTH_BITS-1:0] w_rd_ptr_nxt;

  assign w_full       = (r_count == c_full_cnt);
  assign w_empty      = (r_count == '0);
  assign w_wr_acc     = wr_en && (!w_full || rd_en);
  assign w_rd_acc     = rd_en && !w_empty;
  assign w_rd_ptr_nxt = r_rd_ptr + c_ptr_one;

  // Storage is intentionally left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !reset)
      r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_dout      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc)
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_rd_acc)
        r_rd_ptr <= w_rd_ptr_nxt;

      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase

      // Head register: preload the word that will be oldest after this edge.
      if (w_rd_acc && (r_count > c_one))
        r_dout <= r_mem[w_rd_ptr_nxt];
      else if (w_wr_acc && (w_empty || (w_rd_acc && r_count == c_one)))
        r_dout <= din;

      if (wr_en && w_full && !rd_en)
        r_overflow <= 1'b1;
      else if (err_clr)
        r_overflow <= 1'b0;

      if (rd_en && w_empty)
        r_underflow <= 1'b1;
      else if (err_clr)
        r_underflow <= 1'b0;
    end
  end

  assign dout         = r_dout;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign nearly_full  = (r_count >= c_nf_thresh);
  assign nearly_empty = (r_count <= c_ne_thresh);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fwft_thresh_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fwft_thresh_fifo
//  Brief    : Scoreboard bench for fwft_thresh_fifo (8-bit, depth 4).
//  Revision : 1.0  - initial release
// ============================================================================
module tb_fwft_thresh_fifo;

  localparam int WIDTH = 8;
  localparam int DBITS = 2;
  localparam int DEPTH = 4;
  localparam int NF    = 3;
  localparam int NE    = 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic             wr_en, rd_en, err_clr;
  logic [WIDTH-1:0] dout;
  logic             full, nearly_full, empty, nearly_empty;
  logic [DBITS:0]   count;
  logic             overflow, underflow;

  fwft_thresh_fifo #(
    .WIDTH(WIDTH), .MAX_DEPTH_BITS(DBITS), .NEARLY_FULL(NF), .NEARLY_EMPTY(NE)
  ) u_dut (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .err_clr(err_clr), .dout(dout), .full(full), .nearly_full(nearly_full),
    .empty(empty), .nearly_empty(nearly_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] sb_q [$];
  logic [WIDTH-1:0] m_dout;
  logic             m_ovf, m_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},  32'(count),        32'(sb_q.size()));
    check({tag, ".empty"},  32'(empty),        32'(sb_q.size() == 0));
    check({tag, ".full"},   32'(full),         32'(sb_q.size() == DEPTH));
    check({tag, ".nfull"},  32'(nearly_full),  32'(sb_q.size() >= NF));
    check({tag, ".nempty"}, 32'(nearly_empty), 32'(sb_q.size() <= NE));
    check({tag, ".dout"},   32'(dout),         32'(m_dout));
    check({tag, ".ovf"},    32'(overflow),     32'(m_ovf));
    check({tag, ".unf"},    32'(underflow),    32'(m_unf));
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // One clock: drive at negedge, predict, then check 1 time unit after posedge.
  task automatic cycle(input string tag, input logic wr, input logic [WIDTH-1:0] d,
                       input logic rd, input logic clr);
    bit m_full, m_empty, wr_acc, rd_acc;
    @(negedge clk);
    wr_en = wr; din = d; rd_en = rd; err_clr = clr;
    m_full  = (sb_q.size() == DEPTH);
    m_empty = (sb_q.size() == 0);
    wr_acc  = wr && (!m_full || rd);
    rd_acc  = rd && !m_empty;
    if (wr && m_full && !rd) m_ovf = 1'b1;
    else if (clr)            m_ovf = 1'b0;
    if (rd && m_empty)       m_unf = 1'b1;
    else if (clr)            m_unf = 1'b0;
    @(posedge clk);
    #1;
    if (rd_acc) void'(sb_q.pop_front());
    if (wr_acc) sb_q.push_back(d);
    if (sb_q.size() != 0) m_dout = sb_q[0];
    check_all(tag);
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; din = '0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    cycle("wrA1", 1, 8'hA1, 0, 0);
    check("A1.dout", 32'(dout), 32'hA1);
    cycle("rdA1", 0, 8'h00, 1, 0);

    for (int i = 1; i <= 4; i++) cycle("fill", 1, 8'(i), 0, 0);
    check("fill.full", 32'(full), 32'd1);
    cycle("ovf55", 1, 8'h55, 0, 0);
    check("ovf55.flag", 32'(overflow), 32'd1);
    cycle("wr66rd", 1, 8'h66, 1, 0);
    check("wr66.dout", 32'(dout), 32'h02);
    for (int i = 0; i < 4; i++) cycle("drain", 0, 8'h00, 1, 0);
    cycle("unf", 0, 8'h00, 1, 0);
    cycle("clr_vs_unf", 0, 8'h00, 1, 1);
    check("clr_vs_unf.flag", 32'(underflow), 32'd1);
    cycle("clr", 0, 8'h00, 0, 1);

    cycle("wr10", 1, 8'h10, 0, 0);
    cycle("rdwr20", 1, 8'h20, 1, 0);
    check("rdwr20.dout", 32'(dout), 32'h20);
    cycle("rd20", 0, 8'h00, 1, 0);
    cycle("unf2", 0, 8'h00, 1, 0);
    cycle("clr2", 0, 8'h00, 0, 1);
    cycle("wr_rd_empty", 1, 8'h3C, 1, 0);
    cycle("rd3C", 0, 8'h00, 1, 0);

    for (int i = 0; i < 3; i++) cycle("pre_rst", 1, 8'(8'hB0 + i), 0, 0);
    cycle("pre_rst_ovf", 1, 8'hBF, 0, 0);
    cycle("pre_rst_ovf2", 1, 8'hBE, 0, 0);
    // Asynchronous reset between edges with data queued and a flag set.
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    wr_en = 1'b1; din = 8'hEE;
    @(posedge clk);
    #1;
    check_all("rst_hold_wr");
    @(negedge clk);
    wr_en = 1'b0;
    reset = 1'b0;
    cycle("wr77", 1, 8'h77, 0, 0);
    check("wr77.dout", 32'(dout), 32'h77);

    for (int i = 0; i < 300; i++)
      cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
